// File: rtl/id_stage_hs_if.sv
// Decode-stage bus: IF-side handshake, write-back port, EX hazard info
// and the registered decode outputs toward EX.
interface id_stage_hs_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
);
    localparam int unsigned RW = $clog2(NREG);

    // pipeline control
    logic            flush;

    // upstream (IF) handshake
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    // write-back port
    logic            wb_en;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    // EX-stage load information for hazard detection
    logic            ex_is_load;
    logic [RW-1:0]   ex_rd;

    // downstream (EX) handshake and decoded fields
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [RW-1:0]   out_rd;
    logic [RW-1:0]   out_rs1;
    logic [RW-1:0]   out_rs2;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;

    // driver side: IF, WB and EX stages around the decode stage
    modport master (
        output flush,
        output in_valid, in_inst, in_pc,
        input  in_ready,
        output wb_en, wb_rd, wb_data,
        output ex_is_load, ex_rd,
        output out_ready,
        input  out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
        input  out_func3, out_func7, out_rs1_data, out_rs2_data, out_imm
    );

    // the decode stage itself
    modport slave (
        input  flush,
        input  in_valid, in_inst, in_pc,
        output in_ready,
        input  wb_en, wb_rd, wb_data,
        input  ex_is_load, ex_rd,
        input  out_ready,
        output out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
        output out_func3, out_func7, out_rs1_data, out_rs2_data, out_imm
    );
endinterface

// File: rtl/id_stage_hs.sv
// RV64I instruction-decode stage: field decode, immediate generation,
// register file with write-back bypass, load-use hazard bubbles and a
// valid/ready output register toward EX.
module id_stage_hs #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned NREG      = 32,
    parameter int unsigned BYPASS_EN = 1
) (
    input logic          clk,
    input logic          rst,
    id_stage_hs_if.slave bus
);
    localparam int unsigned RW = $clog2(NREG);

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_OP_IMM   = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_OP_IMM32 = 7'b0011011,
        OP_STORE    = 7'b0100011,
        OP_OP       = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_OP32     = 7'b0111011,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111
    } opcode_e;

    logic [XLEN-1:0] rf [NREG];

    logic [31:0]     inst;
    opcode_e         op;
    logic [RW-1:0]   dec_rd;
    logic [RW-1:0]   dec_rs1;
    logic [RW-1:0]   dec_rs2;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_full;
    logic            rs1_used;
    logic            rs2_used;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            advance;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [6:0]      out_opcode_q;
    logic [RW-1:0]   out_rd_q;
    logic [RW-1:0]   out_rs1_q;
    logic [RW-1:0]   out_rs2_q;
    logic [2:0]      out_func3_q;
    logic [6:0]      out_func7_q;
    logic [XLEN-1:0] out_rs1_data_q;
    logic [XLEN-1:0] out_rs2_data_q;
    logic [XLEN-1:0] out_imm_q;

    assign inst    = bus.in_inst;
    assign op      = opcode_e'(inst[6:0]);
    assign dec_rd  = inst[7 +: RW];
    assign dec_rs1 = inst[15 +: RW];
    assign dec_rs2 = inst[20 +: RW];

    // Immediate format and operand usage selected by opcode
    always_comb begin
        imm32    = '0;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (op)
            OP_OP_IMM, OP_LOAD, OP_JALR, OP_OP_IMM32: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OP_STORE: begin
                imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm32    = {inst[31:12], 12'b0};
                rs1_used = 1'b0;
            end
            OP_JAL: begin
                imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                rs1_used = 1'b0;
            end
            OP_OP, OP_OP32: begin
                rs2_used = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // All formats fit in 32 bits; widening sign-extends from inst[31]
    assign imm_full = XLEN'($signed(imm32));

    // Register read ports: x0 is hard zero, optional same-cycle WB forwarding
    always_comb begin
        rs1_val = rf[dec_rs1];
        rs2_val = rf[dec_rs2];
        if (BYPASS_EN != 0 && bus.wb_en && bus.wb_rd == dec_rs1) begin
            rs1_val = bus.wb_data;
        end
        if (BYPASS_EN != 0 && bus.wb_en && bus.wb_rd == dec_rs2) begin
            rs2_val = bus.wb_data;
        end
        if (dec_rs1 == '0) begin
            rs1_val = '0;
        end
        if (dec_rs2 == '0) begin
            rs2_val = '0;
        end
    end

    // Load-use hazard against the instruction currently in EX
    always_comb begin
        hazard = 1'b0;
        if (bus.in_valid && bus.ex_is_load && bus.ex_rd != '0) begin
            hazard = (rs1_used && bus.ex_rd == dec_rs1) ||
                     (rs2_used && bus.ex_rd == dec_rs2);
        end
    end

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = advance && !hazard && !bus.flush;

    // Register file write; writes to x0 are discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_en && bus.wb_rd != '0) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Output register: flush, capture, bubble, or hold with operand refresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_opcode_q   <= '0;
            out_rd_q       <= '0;
            out_rs1_q      <= '0;
            out_rs2_q      <= '0;
            out_func3_q    <= '0;
            out_func7_q    <= '0;
            out_rs1_data_q <= '0;
            out_rs2_data_q <= '0;
            out_imm_q      <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (advance) begin
            if (bus.in_valid && !hazard) begin
                out_valid_q    <= 1'b1;
                out_pc_q       <= bus.in_pc;
                out_opcode_q   <= inst[6:0];
                out_rd_q       <= dec_rd;
                out_rs1_q      <= dec_rs1;
                out_rs2_q      <= dec_rs2;
                out_func3_q    <= inst[14:12];
                out_func7_q    <= inst[31:25];
                out_rs1_data_q <= rs1_val;
                out_rs2_data_q <= rs2_val;
                out_imm_q      <= imm_full;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else begin
            // A stalled instruction keeps tracking write-backs so EX never
            // receives an operand older than the register file.
            if (bus.wb_en && bus.wb_rd != '0 && bus.wb_rd == out_rs1_q) begin
                out_rs1_data_q <= bus.wb_data;
            end
            if (bus.wb_en && bus.wb_rd != '0 && bus.wb_rd == out_rs2_q) begin
                out_rs2_data_q <= bus.wb_data;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_opcode   = out_opcode_q;
    assign bus.out_rd       = out_rd_q;
    assign bus.out_rs1      = out_rs1_q;
    assign bus.out_rs2      = out_rs2_q;
    assign bus.out_func3    = out_func3_q;
    assign bus.out_func7    = out_func7_q;
    assign bus.out_rs1_data = out_rs1_data_q;
    assign bus.out_rs2_data = out_rs2_data_q;
    assign bus.out_imm      = out_imm_q;
endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: a bypassing instance plus a
// non-bypassing instance that mirrors the same stimulus.
module tb_id_stage_hs;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    id_stage_hs_if #(.XLEN(64), .NREG(32)) bus ();
    id_stage_hs_if #(.XLEN(64), .NREG(32)) bus0 ();

    id_stage_hs #(.XLEN(64), .NREG(32), .BYPASS_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    id_stage_hs #(.XLEN(64), .NREG(32), .BYPASS_EN(0)) dut_nobyp (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    assign bus0.flush      = bus.flush;
    assign bus0.in_valid   = bus.in_valid;
    assign bus0.in_inst    = bus.in_inst;
    assign bus0.in_pc      = bus.in_pc;
    assign bus0.wb_en      = bus.wb_en;
    assign bus0.wb_rd      = bus.wb_rd;
    assign bus0.wb_data    = bus.wb_data;
    assign bus0.ex_is_load = bus.ex_is_load;
    assign bus0.ex_rd      = bus.ex_rd;
    assign bus0.out_ready  = bus.out_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_inst    = '0;
        bus.in_pc      = '0;
        bus.wb_en      = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_data    = '0;
        bus.ex_is_load = 1'b0;
        bus.ex_rd      = '0;
        bus.out_ready  = 1'b0;
        repeat (2) tick();
        check("rst_valid",  64'(bus.out_valid), 64'd0);
        check("rst_opcode", 64'(bus.out_opcode), 64'd0);
        check("rst_imm",    bus.out_imm, 64'd0);
        check("rst_rs1d",   bus.out_rs1_data, 64'd0);
        check("rst_inrdy",  64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        // addi x1,x0,-1
        bus.in_inst   = 32'hFFF0_0093;
        bus.in_pc     = 64'h1000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1 check("t1_inrdy", 64'(bus.in_ready), 64'd1);
        tick();
        check("t1_valid",  64'(bus.out_valid), 64'd1);
        check("t1_imm",    bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_rd",     64'(bus.out_rd), 64'd1);
        check("t1_rs1d",   bus.out_rs1_data, 64'd0);
        check("t1_pc",     bus.out_pc, 64'h1000);
        check("t1_opcode", 64'(bus.out_opcode), 64'h13);

        // rs2 field of an I-type and ex_rd=0 never stall
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd31;
        #1 check("hz_itype_rs2", 64'(bus.in_ready), 64'd1);
        bus.ex_rd      = 5'd0;
        #1 check("hz_exrd0", 64'(bus.in_ready), 64'd1);
        bus.ex_is_load = 1'b0;

        // preload x5 = 0x77
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b1;
        bus.wb_rd    = 5'd5;
        bus.wb_data  = 64'h77;
        tick();
        check("t2_bubble", 64'(bus.out_valid), 64'd0);

        // add x6,x5,x5 while WB writes x5 = 0x1234
        bus.wb_data  = 64'h1234;
        bus.in_inst  = 32'h0052_8333;
        bus.in_valid = 1'b1;
        tick();
        check("t2_byp_rs1",   bus.out_rs1_data, 64'h1234);
        check("t2_byp_rs2",   bus.out_rs2_data, 64'h1234);
        check("t2_rd",        64'(bus.out_rd), 64'd6);
        check("t2_nobyp_rs1", bus0.out_rs1_data, 64'h77);
        check("t2_nobyp_rs2", bus0.out_rs2_data, 64'h77);

        // add x8,x7,x1 behind a load to x7; WB writes x7 during the stall
        bus.wb_rd      = 5'd7;
        bus.wb_data    = 64'hBEEF;
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd7;
        bus.in_inst    = 32'h0013_8433;
        #1 check("t3_inrdy_hz", 64'(bus.in_ready), 64'd0);
        tick();
        check("t3_bubble", 64'(bus.out_valid), 64'd0);
        bus.wb_en = 1'b0;
        bus.ex_rd = 5'd1;
        #1 check("t3_hz_rs2", 64'(bus.in_ready), 64'd0);
        bus.ex_is_load = 1'b0;
        #1 check("t3_inrdy_ok", 64'(bus.in_ready), 64'd1);
        tick();
        check("t3_valid", 64'(bus.out_valid), 64'd1);
        check("t3_rd",    64'(bus.out_rd), 64'd8);
        check("t3_rs1d",  bus.out_rs1_data, 64'hBEEF);
        check("t3_rs2d",  bus.out_rs2_data, 64'd0);

        // lui x3,0x38 has rs1 field 7 but does not read rs1
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd7;
        bus.in_inst    = 32'h0003_81B7;
        #1 check("t3_lui_inrdy", 64'(bus.in_ready), 64'd1);
        tick();
        check("t3_lui_valid", 64'(bus.out_valid), 64'd1);
        check("t3_lui_imm",   bus.out_imm, 64'h38000);
        check("t3_lui_rd",    64'(bus.out_rd), 64'd3);
        bus.ex_is_load = 1'b0;

        // sub x10,x2,x9 then hold it while WB writes x9
        bus.in_inst = 32'h4091_0533;
        tick();
        check("t4_valid", 64'(bus.out_valid), 64'd1);
        check("t4_rs2d0", bus.out_rs2_data, 64'd0);
        check("t4_func7", 64'(bus.out_func7), 64'h20);
        bus.out_ready = 1'b0;
        bus.in_inst   = 32'hFFF0_0093;
        bus.wb_en     = 1'b1;
        bus.wb_rd     = 5'd9;
        bus.wb_data   = 64'hAA;
        #1 check("t4_inrdy_hold", 64'(bus.in_ready), 64'd0);
        tick();
        check("t4_hold_valid", 64'(bus.out_valid), 64'd1);
        check("t4_hold_rd",    64'(bus.out_rd), 64'd10);
        check("t4_hold_rs2d",  bus.out_rs2_data, 64'hAA);
        check("t4_hold_rs1d",  bus.out_rs1_data, 64'd0);
        bus.wb_en     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1 check("t4_release_rs2d", bus.out_rs2_data, 64'hAA);
        tick();
        check("t4_drained", 64'(bus.out_valid), 64'd0);

        // flush with a valid output and a valid input
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'hFFF0_0093;
        bus.in_pc    = 64'h2000;
        tick();
        check("t5_valid", 64'(bus.out_valid), 64'd1);
        bus.flush   = 1'b1;
        bus.in_inst = 32'h0003_81B7;
        #1 check("t5_inrdy", 64'(bus.in_ready), 64'd0);
        tick();
        check("t5_flushed", 64'(bus.out_valid), 64'd0);
        bus.flush = 1'b0;

        // WB to x0 must not leak through bypass or RF
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 64'h55;
        bus.in_inst = 32'h0000_0333;
        tick();
        check("t6_x0_byp_rs1", bus.out_rs1_data, 64'd0);
        check("t6_x0_byp_rs2", bus.out_rs2_data, 64'd0);
        bus.wb_en = 1'b0;
        tick();
        check("t6_x0_rf_rs1", bus.out_rs1_data, 64'd0);
        check("t6_x0_rf_rs2", bus.out_rs2_data, 64'd0);

        // immediate formats
        bus.in_inst = 32'h0080_006F;
        tick();
        check("t6_jal_imm", bus.out_imm, 64'd8);
        check("t6_jal_op",  64'(bus.out_opcode), 64'h6F);
        bus.in_inst = 32'hFE00_0EE3;
        tick();
        check("t6_beq_imm", bus.out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.in_inst = 32'hFE51_2C23;
        tick();
        check("sw_imm",   bus.out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("sw_rs2d",  bus.out_rs2_data, 64'h1234);
        check("sw_func3", 64'(bus.out_func3), 64'd2);
        bus.in_inst = 32'h1234_5297;
        tick();
        check("auipc_imm", bus.out_imm, 64'h1234_5000);
        bus.in_inst = 32'h8000_0037;
        tick();
        check("lui_neg_imm", bus.out_imm, 64'hFFFF_FFFF_8000_0000);

        // asynchronous reset mid-transfer clears outputs and RF
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_imm",   bus.out_imm, 64'd0);
        rst = 1'b0;
        bus.in_inst = 32'h0052_8333;
        tick();
        check("arst_valid2", 64'(bus.out_valid), 64'd1);
        check("arst_rf_rs1", bus.out_rs1_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
